// File: rtl/flash_copy_pkg.sv
// Shared register map, CTRL/STATUS bit positions and sequencer state encoding
// for the flash-to-RAM copy engine.
package flash_copy_pkg;

  localparam logic [3:0] ADDR_SRC  = 4'h0;
  localparam logic [3:0] ADDR_DST  = 4'h4;
  localparam logic [3:0] ADDR_LEN  = 4'h8;
  localparam logic [3:0] ADDR_CTRL = 4'hC;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_ABORT_BIT = 1;

  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_DONE_BIT  = 1;
  localparam int STAT_ERROR_BIT = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } fce_state_e;

endpackage

// File: rtl/fce_regs.sv
// Configuration registers (SRC/DST/LEN), sticky done/error flags and the
// combinational bus read mux for the copy engine.
module fce_regs
  import flash_copy_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_wen,
  input  logic             cfg_ren,
  input  logic [3:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  output logic [31:0]      cfg_rdata,
  input  logic             busy,
  input  logic [LEN_W-1:0] remaining,
  input  logic             start_clr,
  input  logic             set_done,
  input  logic             set_error,
  output logic [31:0]      src,
  output logic [31:0]      dst,
  output logic [LEN_W-1:0] len
);

  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [31:0]      status;

  always_comb begin
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    done_d  = done_q;
    error_d = error_q;
    // Configuration is frozen while a copy owns the flash/RAM ports.
    if (cfg_wen && !busy) begin
      case (cfg_addr)
        ADDR_SRC: src_d = {cfg_wdata[31:2], 2'b00};
        ADDR_DST: dst_d = {cfg_wdata[31:2], 2'b00};
        ADDR_LEN: len_d = cfg_wdata[LEN_W-1:0];
        default: ;
      endcase
    end
    if (start_clr) begin
      done_d  = 1'b0;
      error_d = 1'b0;
    end
    if (set_done)  done_d  = 1'b1;
    if (set_error) error_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    status                 = '0;
    status[STAT_BUSY_BIT]  = busy;
    status[STAT_DONE_BIT]  = done_q;
    status[STAT_ERROR_BIT] = error_q;
    status[31:16]          = 16'(remaining);
    cfg_rdata              = '0;
    if (cfg_ren) begin
      case (cfg_addr)
        ADDR_SRC:  cfg_rdata = src_q;
        ADDR_DST:  cfg_rdata = dst_q;
        ADDR_LEN:  cfg_rdata = 32'(len_q);
        ADDR_CTRL: cfg_rdata = status;
        default:   cfg_rdata = '0;
      endcase
    end
  end

  assign src = src_q;
  assign dst = dst_q;
  assign len = len_q;

endmodule

// File: rtl/flash_copy_engine.sv
// Copy sequencer: reads LEN words from the flash controller and writes them to
// program RAM, one word per REQ/WAIT/WRITE round, with timeout and abort.
module flash_copy_engine
  import flash_copy_pkg::*;
#(
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_wen,
  input  logic        cfg_ren,
  input  logic [3:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  output logic        flash_ren,
  output logic [31:0] flash_addr,
  input  logic        flash_rvalid,
  input  logic [31:0] flash_rdata,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_select,
  output logic        busy,
  output logic        done_irq
);

  localparam int TW = $clog2(TIMEOUT + 1);

  fce_state_e       state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [31:0]      src_q, src_d, dst_q, dst_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             flash_ren_q, flash_ren_d, mem_wen_q, mem_wen_d;
  logic [31:0]      flash_addr_q, flash_addr_d, mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic             busy_q, busy_d, done_irq_q, done_irq_d;
  logic             start_acc, abort_acc, err_set;
  logic [31:0]      cfg_src, cfg_dst;
  logic [LEN_W-1:0] cfg_len;

  fce_regs #(.LEN_W(LEN_W)) u_regs (
    .clk       (clk),
    .reset     (reset),
    .cfg_wen   (cfg_wen),
    .cfg_ren   (cfg_ren),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .busy      (busy_q),
    .remaining (cnt_q),
    .start_clr (start_acc),
    .set_done  (state_q == ST_DONE),
    .set_error (err_set),
    .src       (cfg_src),
    .dst       (cfg_dst),
    .len       (cfg_len)
  );

  // ABORT only bites while words are still moving; START only from IDLE.
  assign start_acc = cfg_wen && (cfg_addr == ADDR_CTRL) && cfg_wdata[CTRL_START_BIT]
                     && (state_q == ST_IDLE);
  assign abort_acc = cfg_wen && (cfg_addr == ADDR_CTRL) && cfg_wdata[CTRL_ABORT_BIT]
                     && (state_q inside {ST_REQ, ST_WAIT, ST_WRITE});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    dst_d   = dst_q;
    timer_d = timer_q;
    err_set = 1'b0;
    case (state_q)
      ST_IDLE: if (start_acc) begin
        cnt_d   = cfg_len;
        src_d   = cfg_src;
        dst_d   = cfg_dst;
        state_d = (cfg_len == '0) ? ST_DONE : ST_REQ;
      end
      ST_REQ: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (flash_rvalid) begin
          state_d = ST_WRITE;
        end else if (timer_q == TW'(TIMEOUT)) begin
          state_d = ST_DONE;
          err_set = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_WRITE: begin
        src_d   = src_q + 32'd4;
        dst_d   = dst_q + 32'd4;
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == LEN_W'(1)) ? ST_DONE : ST_REQ;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // The write already on the bus this cycle still lands; nothing new starts.
    if (abort_acc) begin
      state_d = ST_DONE;
      err_set = 1'b1;
    end
    // Outputs are registered: they describe the state being entered.
    flash_ren_d  = (state_d == ST_REQ);
    flash_addr_d = (state_d == ST_REQ) ? src_d : '0;
    mem_wen_d    = (state_d == ST_WRITE);
    mem_addr_d   = (state_d == ST_WRITE) ? dst_d : '0;
    mem_wdata_d  = (state_d == ST_WRITE) ? flash_rdata : '0;
    busy_d       = (state_d != ST_IDLE);
    done_irq_d   = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      src_q        <= '0;
      dst_q        <= '0;
      timer_q      <= '0;
      flash_ren_q  <= 1'b0;
      flash_addr_q <= '0;
      mem_wen_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      done_irq_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      timer_q      <= timer_d;
      flash_ren_q  <= flash_ren_d;
      flash_addr_q <= flash_addr_d;
      mem_wen_q    <= mem_wen_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
      done_irq_q   <= done_irq_d;
    end
  end

  assign flash_ren       = flash_ren_q;
  assign flash_addr      = flash_addr_q;
  assign mem_wen         = mem_wen_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;
  assign mem_byte_select = mem_wen_q ? 4'hF : 4'h0;
  assign busy            = busy_q;
  assign done_irq        = done_irq_q;

endmodule
